// File: rtl/div_if.sv
// ============================================================================
// div_if : operand/result bundle between the EX stage and the divider
// Rev 1.0
// ============================================================================
`default_nettype none

interface div_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             kill;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, kill, op, a, b,
      input  busy, done, result
   );

   modport slave (
      input  start, kill, op, a, b,
      output busy, done, result
   );
endinterface

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// div_unit : iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
// Rev 1.0
// ============================================================================
`default_nettype none

module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic clk,
   input  logic rst,
   div_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [1:0]       op_q, op_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             signed_op;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             div_zero, sgn_ovf;
   logic [WIDTH:0]   shifted, trial;
   logic             trial_neg;
   logic [WIDTH-1:0] rem_next, quo_next;
   logic [WIDTH-1:0] final_val;

   // Operand conditioning for a request arriving this cycle
   assign signed_op = ~bus.op[0];
   assign a_neg     = signed_op & bus.a[WIDTH-1];
   assign b_neg     = signed_op & bus.b[WIDTH-1];
   assign a_mag     = a_neg ? -bus.a : bus.a;
   assign b_mag     = b_neg ? -bus.b : bus.b;
   assign div_zero  = (bus.b == '0);
   assign sgn_ovf   = signed_op & (bus.a == INT_MIN) & (bus.b == ALL_ONES);

   // One restoring step; the extra top bit keeps the trial sign exact
   assign shifted   = {1'b0, rem_q[WIDTH-1:0]} << 1 | {{WIDTH{1'b0}}, quo_q[WIDTH-1]};
   assign trial     = shifted - {1'b0, dvs_q};
   assign trial_neg = trial[WIDTH];
   assign rem_next  = trial_neg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quo_next  = {quo_q[WIDTH-2:0], ~trial_neg};

   // Remainder takes the dividend's sign, quotient the XOR of both signs
   assign final_val = op_q[1] ? (rneg_q ? -rem_next : rem_next)
                              : (qneg_q ? -quo_next : quo_next);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      op_d     = op_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.start) begin
               op_d   = bus.op;
               qneg_d = a_neg ^ b_neg;
               rneg_d = a_neg;
               if (div_zero) begin
                  result_d = bus.op[1] ? bus.a : ALL_ONES;
                  state_d  = DONE;
                  done_d   = 1'b1;
               end else if (sgn_ovf) begin
                  result_d = bus.op[1] ? '0 : INT_MIN;
                  state_d  = DONE;
                  done_d   = 1'b1;
               end else begin
                  cnt_d   = '0;
                  rem_d   = '0;
                  quo_d   = a_mag;
                  dvs_d   = b_mag;
                  state_d = CALC;
                  busy_d  = 1'b1;
               end
            end
         end
         CALC: begin
            rem_d = rem_next;
            quo_d = quo_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               result_d = final_val;
               state_d  = DONE;
               done_d   = 1'b1;
            end else begin
               busy_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A flush beats everything, including a same-cycle start
      if (bus.kill) begin
         state_d  = IDLE;
         busy_d   = 1'b0;
         done_d   = 1'b0;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         op_q     <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         op_q     <= op_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// tb_div_unit : directed and randomised scoreboard bench for div_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_div_unit;

   localparam int WIDTH = 32;

   logic clk;
   logic rst;

   div_if #(.WIDTH(WIDTH)) dif ();

   div_unit #(.WIDTH(WIDTH), .CNT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb_q[$];
   logic [31:0] last_exp = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [31:0] sa, sb;
      logic               ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      case (op)
         2'b00:   return ovf ? 32'h8000_0000 : 32'(sa / sb);
         2'b01:   return a / b;
         2'b10:   return ovf ? 32'd0 : 32'(sa % sb);
         default: return a % b;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      dif.start = 1'b1;
      dif.op    = op;
      dif.a     = a;
      dif.b     = b;
   endtask

   // Waits for done, counting edges from the one that samples start
   task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
      int          n   = 0;
      int          nb  = 0;
      bit          got = 1'b0;
      logic [31:0] exp;
      for (int i = 1; i <= 60 && !got; i++) begin
         tick();
         if (i == 1) dif.start = 1'b0;
         n = i;
         if (dif.busy) nb++;
         if (dif.done) got = 1'b1;
      end
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
      chk({tag, "_done_seen"}, 32'(got), 32'd1);
      chk({tag, "_result"}, dif.result, exp);
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
      chk({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
      last_exp = exp;
   endtask

   initial begin
      int          cnt;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      int          lat;

      rst       = 1'b1;
      dif.start = 1'b0;
      dif.kill  = 1'b0;
      dif.op    = 2'b00;
      dif.a     = '0;
      dif.b     = '0;
      repeat (3) tick();
      chk("reset_busy", 32'(dif.busy), 32'd0);
      chk("reset_done", 32'(dif.done), 32'd0);
      chk("reset_result", dif.result, 32'd0);
      rst = 1'b0;
      tick();

      // Signed divide and remainder of -7 by 2
      sb_q.push_back(32'hFFFF_FFFD);
      drive(2'b00, 32'hFFFF_FFF9, 32'd2);
      wait_done("div_m7_2", 33, 32);
      tick();
      chk("done_one_cycle", 32'(dif.done), 32'd0);
      sb_q.push_back(32'hFFFF_FFFF);
      drive(2'b10, 32'hFFFF_FFF9, 32'd2);
      wait_done("rem_m7_2", 33, 32);

      // Back-to-back: second start issued in the DONE cycle of the first
      tick();
      sb_q.push_back(32'd14);
      drive(2'b01, 32'd100, 32'd7);
      wait_done("divu_100_7", 33, 32);
      sb_q.push_back(32'd2);
      drive(2'b11, 32'd100, 32'd7);
      wait_done("remu_100_7_b2b", 33, 32);

      // Divide by zero and signed overflow complete in one edge
      tick();
      sb_q.push_back(32'hFFFF_FFFF);
      drive(2'b00, 32'd5, 32'd0);
      wait_done("div_by0", 1, 0);
      sb_q.push_back(32'd5);
      drive(2'b10, 32'd5, 32'd0);
      wait_done("rem_by0", 1, 0);
      sb_q.push_back(32'h8000_0000);
      drive(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_ovf", 1, 0);
      sb_q.push_back(32'd0);
      drive(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("rem_ovf", 1, 0);

      // kill sampled on edge 10 of a running DIVU
      tick();
      drive(2'b01, 32'hFFFF_FFFF, 32'd3);
      for (int i = 1; i <= 9; i++) begin
         tick();
         if (i == 1) dif.start = 1'b0;
      end
      dif.kill = 1'b1;
      tick();
      dif.kill = 1'b0;
      chk("kill_busy", 32'(dif.busy), 32'd0);
      chk("kill_done", 32'(dif.done), 32'd0);
      chk("kill_result_kept", dif.result, last_exp);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (dif.done || dif.busy) cnt++;
      end
      chk("kill_no_activity", 32'(cnt), 32'd0);

      // kill and start together: nothing starts
      drive(2'b01, 32'd100, 32'd7);
      dif.kill = 1'b1;
      tick();
      dif.start = 1'b0;
      dif.kill  = 1'b0;
      chk("killstart_busy", 32'(dif.busy), 32'd0);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (dif.done || dif.busy) cnt++;
      end
      chk("killstart_no_activity", 32'(cnt), 32'd0);
      chk("killstart_result_kept", dif.result, last_exp);

      // Randomised operations against the reference model
      for (int i = 0; i < 6; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (i == 5) rb = 32'hFFFF_FFF3;
         lat = (rb == 32'd0) ? 1 : 33;
         sb_q.push_back(ref_div(rop, ra, rb));
         drive(rop, ra, rb);
         wait_done($sformatf("rand%0d_op%0d", i, rop), lat, lat - 1);
      end

      // Reset in the middle of an operation
      tick();
      drive(2'b01, 32'hFFFF_FFFF, 32'd3);
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i == 1) dif.start = 1'b0;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", 32'(dif.busy), 32'd0);
      chk("midrst_done", 32'(dif.done), 32'd0);
      chk("midrst_result", dif.result, 32'd0);
      tick();
      sb_q.push_back(32'h5555_5555);
      drive(2'b01, 32'hFFFF_FFFF, 32'd3);
      wait_done("divu_after_rst", 33, 32);

      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
- Sits in the EX stage beside the combinational ALU. It takes the same forwarded operands and drives its result into the EX/MEM register.
- While it is busy, the hazard unit stalls IF/ID/EX, which removes the long combinational divide path from the ALU.

Parameters:
- WIDTH, 32, operand and result width; the iteration count equals WIDTH.
- CNT_W, 5, iteration counter width; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a divide; sampled only in IDLE or DONE.
- kill  input  1  pipeline flush; aborts any operation in flight.
- op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- a  input  WIDTH  dividend (rs1).
- b  input  WIDTH  divisor (rs2).
- busy  output  1  high while iterating; the hazard unit stalls on it.
- done  output  1  one-cycle pulse; result is valid in the same cycle.
- result  output  WIDTH  quotient or remainder; held until the next completion or reset.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values: state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0.
- rst asserted mid-operation returns the block to IDLE next edge with reset values; no done is produced.

States: IDLE, CALC, DONE.
- IDLE/DONE, start=1 and kill=0:
  - Latch op.
  - Signed ops (DIV, REM): take |a| and |b|; record qneg = a[31]^b[31] and rneg = a[31].
  - Unsigned ops: take a and b as-is; qneg = rneg = 0.
  - Special cases go straight to DONE with result written on the same edge:
    - b==0: DIV/DIVU -> all ones; REM/REMU -> a.
    - Signed overflow (a==0x80000000, b==0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
  - Otherwise go to CALC: counter=0, remainder register=0, quotient register=|a|.
- CALC, one quotient bit per edge:
  - {rem,quo} shifts left 1. trial = rem - divisor.
  - If trial is non-negative: rem=trial and the quotient LSB=1. Else the LSB=0.
  - counter increments each edge.
  - On the edge where counter==WIDTH-1: form the final value, negated if qneg (quotient ops) or rneg (remainder ops). Write it to result and go to DONE.
- DONE: done=1 for exactly one cycle, busy=0.
  - start in DONE behaves as in IDLE (back-to-back ops allowed).
  - Otherwise go to IDLE.
- busy=1 exactly while in CALC.
- start is ignored in CALC. Operand changes during CALC have no effect.

Latency, counting the edge that samples start as edge 1:
- Normal op: done high after edge WIDTH+1 (33).
- Special case: done high after edge 1.

kill:
- Any state, kill=1: next state IDLE, busy=0, done=0. result keeps its previous value.
- kill and start high in the same cycle: kill wins and no op starts.

Arithmetic:
- The internal remainder path is WIDTH+1 bits so the trial subtract sign is exact.
- Negation is two's complement modulo 2^WIDTH.
- Remainder sign follows the dividend. Quotient truncates toward zero.

Test Plan:
- DIV a=0xFFFFFFF9 (-7), b=2 -> done after 33 edges, result=0xFFFFFFFD. Repeat with REM -> result=0xFFFFFFFF. busy high for exactly 32 cycles.
- DIVU a=100, b=7 -> result=14. REMU -> result=2. Issue start in the DONE cycle of the first op; the second op completes 33 edges later with no idle gap.
- Divide by zero: DIV a=5, b=0 -> done after 1 edge, result=0xFFFFFFFF. REM a=5, b=0 -> result=5. busy never asserts.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000. REM -> result=0. Both complete in 1 edge.
- kill asserted on edge 10 of a DIVU 0xFFFFFFFF/3 -> busy=0 next cycle, no done pulse, result unchanged. kill+start together in IDLE -> no op starts.
- rst asserted mid-CALC -> next edge busy=0, done=0, result=0. A following DIVU 0xFFFFFFFF/3 -> result=0x55555555.
